// File: rtl/lc3_mem_defs.sv
// Shared definitions for the LC-3 memory arbiter: FSM state encodings and owner IDs.
package lc3_mem_defs;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LD  = 1'b1;

endpackage

// File: rtl/lc3_rr_arbiter2.sv
// Two-way round-robin arbiter; bit 0 is the CPU, bit 1 the loader. CPU wins the first tie.
module lc3_rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Set when the loader holds priority for the next tie.
    logic prio_q;

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            prio_q <= grant[0];
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares one synchronous-read RAM between the LC-3 CPU memory path and a loader port,
// one access in flight, fixed latency, round-robin arbitration.
module lc3_mem_arbiter
    import lc3_mem_defs::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned EXTRA_WAIT  = 0,
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 16
) (
    input  logic          i_clk,
    input  logic          i_Reset,
    input  logic          i_cpu_mio_en,
    input  logic          i_cpu_r_w,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic [DW-1:0] o_cpu_rdata,
    output logic          o_cpu_ready,
    input  logic          i_ld_req,
    input  logic          i_ld_we,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [DW-1:0] i_ld_wdata,
    output logic [DW-1:0] o_ld_rdata,
    output logic          o_ld_ack,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_busy
);

    localparam int unsigned CW = $clog2(MEM_LATENCY + EXTRA_WAIT + 1);
    localparam logic [CW-1:0] CntInit = CW'(MEM_LATENCY + EXTRA_WAIT - 1);
    // Counter value in WAIT on the cycle that lies MEM_LATENCY after ISSUE.
    localparam logic [CW-1:0] CntCap  = CW'(EXTRA_WAIT);

    arb_state_t    state_q, state_d;
    logic          owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] ld_rdata_q;

    logic [1:0] req;
    logic [1:0] grant;
    logic       take;

    assign req  = {i_ld_req, i_cpu_mio_en};
    assign take = (state_q == StIdle) && (req != 2'b00);

    lc3_rr_arbiter2 u_rr (
        .clk     (i_clk),
        .reset   (i_Reset),
        .req     (req),
        .advance (take),
        .grant   (grant)
    );

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            state_q     <= StIdle;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            // Request copies change only at grant, so the RAM-side outputs hold between accesses.
            if (take) begin
                owner_q <= grant[1] ? OWN_LD : OWN_CPU;
                we_q    <= grant[1] ? i_ld_we    : i_cpu_r_w;
                addr_q  <= grant[1] ? i_ld_addr  : i_cpu_addr;
                wdata_q <= grant[1] ? i_ld_wdata : i_cpu_wdata;
            end
            if (state_q == StIssue) begin
                cnt_q <= CntInit;
            end else if ((state_q == StWait) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if ((state_q == StWait) && (cnt_q == CntCap)) begin
                if (owner_q == OWN_LD) begin
                    ld_rdata_q <= i_mem_rdata;
                end else begin
                    cpu_rdata_q <= i_mem_rdata;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req != 2'b00) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (cnt_q == '0) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign o_mem_en    = (state_q == StIssue);
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_cpu_ready = (state_q == StResp) && (owner_q == OWN_CPU);
    assign o_ld_ack    = (state_q == StResp) && (owner_q == OWN_LD);
    assign o_cpu_rdata = cpu_rdata_q;
    assign o_ld_rdata  = ld_rdata_q;
    assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: one instance at latency 1, one at latency 3 plus 2 waits.
module tb_lc3_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: MEM_LATENCY=1, EXTRA_WAIT=0
    logic        a_rst = 1'b1;
    logic        a_cpu_en = 1'b0, a_cpu_rw = 1'b0;
    logic [15:0] a_cpu_addr = '0, a_cpu_wdata = '0, a_cpu_rdata;
    logic        a_cpu_ready;
    logic        a_ld_req = 1'b0, a_ld_we = 1'b0;
    logic [15:0] a_ld_addr = '0, a_ld_wdata = '0, a_ld_rdata;
    logic        a_ld_ack, a_mem_en, a_mem_we, a_busy;
    logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [15:0] ram_a [0:65535];

    // Instance B: MEM_LATENCY=3, EXTRA_WAIT=2
    logic        b_rst = 1'b1;
    logic        b_cpu_en = 1'b0, b_cpu_rw = 1'b0;
    logic [15:0] b_cpu_addr = '0, b_cpu_wdata = '0, b_cpu_rdata;
    logic        b_cpu_ready;
    logic        b_ld_req = 1'b0, b_ld_we = 1'b0;
    logic [15:0] b_ld_addr = '0, b_ld_wdata = '0, b_ld_rdata;
    logic        b_ld_ack, b_mem_en, b_mem_we, b_busy;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [15:0] b_s0, b_s1;
    logic [15:0] ram_b [0:65535];

    lc3_mem_arbiter #(.MEM_LATENCY(1), .EXTRA_WAIT(0), .AW(16), .DW(16)) dut_a (
        .i_clk(clk), .i_Reset(a_rst),
        .i_cpu_mio_en(a_cpu_en), .i_cpu_r_w(a_cpu_rw), .i_cpu_addr(a_cpu_addr),
        .i_cpu_wdata(a_cpu_wdata), .o_cpu_rdata(a_cpu_rdata), .o_cpu_ready(a_cpu_ready),
        .i_ld_req(a_ld_req), .i_ld_we(a_ld_we), .i_ld_addr(a_ld_addr),
        .i_ld_wdata(a_ld_wdata), .o_ld_rdata(a_ld_rdata), .o_ld_ack(a_ld_ack),
        .o_mem_en(a_mem_en), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr),
        .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata), .o_busy(a_busy)
    );

    lc3_mem_arbiter #(.MEM_LATENCY(3), .EXTRA_WAIT(2), .AW(16), .DW(16)) dut_b (
        .i_clk(clk), .i_Reset(b_rst),
        .i_cpu_mio_en(b_cpu_en), .i_cpu_r_w(b_cpu_rw), .i_cpu_addr(b_cpu_addr),
        .i_cpu_wdata(b_cpu_wdata), .o_cpu_rdata(b_cpu_rdata), .o_cpu_ready(b_cpu_ready),
        .i_ld_req(b_ld_req), .i_ld_we(b_ld_we), .i_ld_addr(b_ld_addr),
        .i_ld_wdata(b_ld_wdata), .o_ld_rdata(b_ld_rdata), .o_ld_ack(b_ld_ack),
        .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
        .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata), .o_busy(b_busy)
    );

    // RAM models: read data appears MEM_LATENCY cycles after the enable cycle.
    always @(posedge clk) begin
        if (a_mem_en) begin
            if (a_mem_we) ram_a[a_mem_addr] <= a_mem_wdata;
            a_mem_rdata <= ram_a[a_mem_addr];
        end
    end

    always @(posedge clk) begin
        if (b_mem_en) begin
            if (b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
            b_s0 <= ram_b[b_mem_addr];
        end
        b_s1        <= b_s0;
        b_mem_rdata <= b_s1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access on instance A, started at a negedge while idle; cycle c is c edges later.
    task automatic a_access(input string tag, input bit is_ld, input bit we,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] rexp);
        if (is_ld) begin
            a_ld_req = 1'b1; a_ld_we = we; a_ld_addr = addr; a_ld_wdata = wdata;
        end else begin
            a_cpu_en = 1'b1; a_cpu_rw = we; a_cpu_addr = addr; a_cpu_wdata = wdata;
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk({tag, "_en"}, 32'(a_mem_en), 32'(c == 1));
            chk({tag, "_ready"}, 32'(a_cpu_ready), 32'(!is_ld && c == 3));
            chk({tag, "_ack"}, 32'(a_ld_ack), 32'(is_ld && c == 3));
            chk({tag, "_busy"}, 32'(a_busy), 32'(c <= 3));
            if (c <= 2) begin
                chk({tag, "_addr"}, 32'(a_mem_addr), 32'(addr));
                chk({tag, "_we"}, 32'(a_mem_we), 32'(we));
                if (we) chk({tag, "_wdata"}, 32'(a_mem_wdata), 32'(wdata));
            end
            if (c == 1) begin
                // Post-grant input changes must not reach the RAM.
                a_cpu_addr = ~addr; a_ld_addr = ~addr; a_cpu_wdata = ~wdata; a_ld_wdata = ~wdata;
            end
            if (c == 3) begin
                if (!we && !is_ld) chk({tag, "_rdata"}, 32'(a_cpu_rdata), 32'(rexp));
                if (!we && is_ld)  chk({tag, "_rdata"}, 32'(a_ld_rdata), 32'(rexp));
                a_cpu_en = 1'b0; a_ld_req = 1'b0;
            end
        end
    endtask

    // One access on instance B; the request is dropped at cycle drop_at.
    task automatic b_access(input string tag, input bit is_ld, input bit we,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] rexp, input int drop_at);
        if (is_ld) begin
            b_ld_req = 1'b1; b_ld_we = we; b_ld_addr = addr; b_ld_wdata = wdata;
        end else begin
            b_cpu_en = 1'b1; b_cpu_rw = we; b_cpu_addr = addr; b_cpu_wdata = wdata;
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk({tag, "_en"}, 32'(b_mem_en), 32'(c == 1));
            chk({tag, "_ready"}, 32'(b_cpu_ready), 32'(!is_ld && c == 7));
            chk({tag, "_ack"}, 32'(b_ld_ack), 32'(is_ld && c == 7));
            chk({tag, "_busy"}, 32'(b_busy), 32'(c <= 7));
            if (c == 1) chk({tag, "_addr"}, 32'(b_mem_addr), 32'(addr));
            if (c == 4 && !we) chk({tag, "_memrd"}, 32'(b_mem_rdata), 32'(rexp));
            if (c == 7 && !we && !is_ld) chk({tag, "_rdata"}, 32'(b_cpu_rdata), 32'(rexp));
            if (c == 7 && !we && is_ld)  chk({tag, "_rdata"}, 32'(b_ld_rdata), 32'(rexp));
            if (c == drop_at) begin
                b_cpu_en = 1'b0; b_ld_req = 1'b0;
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a_busy", 32'(a_busy), 0);
        chk("rst_a_out", {a_mem_addr, a_cpu_rdata}, 0);
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        chk("rst_a_ready", 32'({a_cpu_ready, a_ld_ack, a_mem_en, a_mem_we}), 0);
        chk("rst_b_busy", 32'({b_busy, b_cpu_ready, b_ld_ack, b_mem_en}), 0);
        chk("rst_b_out", {b_mem_addr, b_mem_wdata}, 0);

        // Latency 1: loader writes, CPU reads back
        a_access("a_ldw3000", 1'b1, 1'b1, 16'h3000, 16'h1234, 16'h0000);
        a_access("a_cpurd3000", 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234);
        a_access("a_ldw0200", 1'b1, 1'b1, 16'h0200, 16'hBEEF, 16'h0000);
        a_access("a_cpurd0200", 1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF);
        a_access("a_cpuw0300", 1'b0, 1'b1, 16'h0300, 16'h00A5, 16'h0000);
        a_access("a_ldrd0300", 1'b1, 1'b0, 16'h0300, 16'h0000, 16'h00A5);

        // Round robin from reset: CPU, LD, CPU, LD while both hold their requests
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        a_cpu_en = 1'b1; a_cpu_rw = 1'b0; a_cpu_addr = 16'h3000;
        a_ld_req = 1'b1; a_ld_we = 1'b0; a_ld_addr = 16'h0200;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk("rr_en", 32'(a_mem_en), 32'(c % 4 == 1));
            if (c % 4 == 1)
                chk("rr_addr", 32'(a_mem_addr), (((c - 1) / 4) % 2 == 0) ? 32'h3000 : 32'h0200);
            chk("rr_ready", 32'(a_cpu_ready), 32'(c == 3 || c == 11));
            chk("rr_ack", 32'(a_ld_ack), 32'(c == 7 || c == 15));
            if (c == 3 || c == 11) chk("rr_cpu_rdata", 32'(a_cpu_rdata), 32'h1234);
            if (c == 7 || c == 15) chk("rr_ld_rdata", 32'(a_ld_rdata), 32'hBEEF);
            if (c == 15) begin
                a_cpu_en = 1'b0; a_ld_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("rr_idle", 32'(a_busy), 0);

        // Latency 3 + 2 waits
        b_access("b_ldw3000", 1'b1, 1'b1, 16'h3000, 16'h5678, 16'h0000, 7);
        b_access("b_cpurd3000", 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h5678, 7);

        // Reset during WAIT
        b_cpu_en = 1'b1; b_cpu_rw = 1'b0; b_cpu_addr = 16'h3000;
        repeat (3) @(negedge clk);
        chk("b_mid_busy", 32'(b_busy), 1);
        b_rst = 1'b1; b_cpu_en = 1'b0;
        @(negedge clk);
        chk("b_mid_rst_busy", 32'(b_busy), 0);
        chk("b_mid_rst_ready", 32'(b_cpu_ready), 0);
        chk("b_mid_rst_out", {b_mem_addr, b_cpu_rdata}, 0);
        b_rst = 1'b0;
        @(negedge clk);
        chk("b_post_rst_ready", 32'({b_cpu_ready, b_busy}), 0);
        b_access("b_after_rst", 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h5678, 7);

        // Loader drops its request during WAIT of a write
        b_access("b_lddrop", 1'b1, 1'b1, 16'h0400, 16'hCAFE, 16'h0000, 3);
        b_access("b_rd0400", 1'b0, 1'b0, 16'h0400, 16'h0000, 16'hCAFE, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
